ov_cap: RTL and testbench

//  Parametrised OV-series camera capture front-end, clk_sys domain. Oversamples vsync/href/pclk/data,

---
 rtl/ov_cap.sv | 216 +++++++++++++++++++++
 tb/tb_ov_cap.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov_cap.sv
// OV-series camera capture front-end: oversampled pins, vsync filter, byte packing,
// one-word hold stage for end-of-line tagging, show-ahead output FIFO and status counters.
module ov_cap #(
  parameter int DW         = 8,
  parameter int VS_FILT    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              ov_vsync,
  input  logic              ov_href,
  input  logic              ov_pclk,
  input  logic [DW-1:0]     ov_data,
  input  logic              cfg_en,
  input  logic              cfg_vs_pol,
  input  logic              cfg_pack,
  input  logic              clr_ovf,
  output logic [2*DW-1:0]   m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  stu_line_len,
  output logic [CNT_W-1:0]  stu_frame_lines,
  output logic [CNT_W-1:0]  stu_frame_cnt,
  output logic              stu_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2*DW + 2;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VS, ST_ACTIVE} state_t;
  state_t r_state, w_state_nxt;

  logic               r_vs_m, r_vs_s, r_href_m, r_href_s, r_href_d;
  logic               r_pclk_m, r_pclk_s, r_pclk_d;
  logic [DW-1:0]      r_data_m, r_data_s;
  logic [VS_FILT-1:0] r_vs_sh;
  logic               r_vs_f, r_vs_f_d, r_vs_armed;

  logic               w_pclk_rise, w_href_fall, w_vs_rise, w_vs_fall;
  logic               w_active, w_frame_end, w_line_end, w_cap, w_new_word;
  logic [2*DW-1:0]    w_new_data;
  logic               w_push, w_wr_ok, w_pop, w_empty, w_full;
  logic [EW-1:0]      w_push_entry, w_head;
  logic [CNT_W-1:0]   w_lines_tot;

  logic [DW-1:0]      r_byte_hi;
  logic               r_half, r_hold_valid, r_hold_sof, r_sof_pend;
  logic [2*DW-1:0]    r_hold_data;
  logic [CNT_W-1:0]   r_byte_cnt, r_line_cnt, r_line_len, r_frame_lines, r_frame_cnt;
  logic               r_ovf;
  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]        r_wr, r_rd;

  // Data rides the same two-flop pipeline as pclk so the byte lines up with its edge.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      {r_vs_m, r_vs_s, r_href_m, r_href_s, r_href_d} <= '0;
      {r_pclk_m, r_pclk_s, r_pclk_d}                 <= '0;
      r_data_m <= '0;
      r_data_s <= '0;
      r_vs_sh  <= '0;
      r_vs_f   <= 1'b0;
      r_vs_f_d <= 1'b0;
    end else begin
      r_vs_m   <= ov_vsync;
      r_vs_s   <= r_vs_m;
      r_href_m <= ov_href;
      r_href_s <= r_href_m;
      r_href_d <= r_href_s;
      r_pclk_m <= ov_pclk;
      r_pclk_s <= r_pclk_m;
      r_pclk_d <= r_pclk_s;
      r_data_m <= ov_data;
      r_data_s <= r_data_m;
      r_vs_sh  <= {r_vs_sh[VS_FILT-2:0], r_vs_s ^ ~cfg_vs_pol};
      if (&r_vs_sh)       r_vs_f <= 1'b1;
      else if (~|r_vs_sh) r_vs_f <= 1'b0;
      r_vs_f_d <= r_vs_f;
    end
  end

  assign w_pclk_rise = r_pclk_s & ~r_pclk_d;
  assign w_href_fall = r_href_d & ~r_href_s;
  assign w_vs_rise   = r_vs_f & ~r_vs_f_d;
  assign w_vs_fall   = ~r_vs_f & r_vs_f_d;

  // Arming on a rise makes a mid-frame enable wait for a complete vsync pulse.
  always_ff @(posedge clk_sys) begin
    if (!rst_n || r_state == ST_IDLE) r_vs_armed <= 1'b0;
    else if (w_vs_rise)               r_vs_armed <= 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (cfg_en) w_state_nxt = ST_WAIT_VS;
      ST_WAIT_VS: if (!cfg_en) w_state_nxt = ST_IDLE;
                  else if (r_vs_armed && w_vs_fall) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE:  if (!cfg_en) w_state_nxt = ST_IDLE;
                  else if (w_vs_rise) w_state_nxt = ST_WAIT_VS;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_active     = (r_state == ST_ACTIVE) && cfg_en;
    w_frame_end  = w_active && w_vs_rise;
    w_line_end   = w_active && w_href_fall;
    w_cap        = w_active && w_pclk_rise && r_href_s && !w_vs_rise;
    w_new_word   = w_cap && (!cfg_pack || r_half);
    w_new_data   = cfg_pack ? {r_byte_hi, r_data_s} : {{DW{1'b0}}, r_data_s};
    w_push       = r_hold_valid && (w_new_word || w_line_end || w_frame_end);
    w_push_entry = {r_hold_sof, w_line_end | w_frame_end, r_hold_data};
    w_lines_tot  = (w_line_end && !(&r_line_cnt)) ? r_line_cnt + CNT_ONE : r_line_cnt;
  end

  // sof is latched onto a word when it enters the hold stage; words leave it in order.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_byte_hi    <= '0;
      r_half       <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_sof   <= 1'b0;
      r_hold_data  <= '0;
      r_sof_pend   <= 1'b0;
    end else if (!w_active) begin
      r_half       <= 1'b0;
      r_hold_valid <= 1'b0;
      r_sof_pend   <= 1'b1;
    end else if (w_frame_end || w_line_end) begin
      r_half       <= 1'b0;
      r_hold_valid <= 1'b0;
    end else if (w_cap) begin
      if (w_new_word) begin
        r_hold_data  <= w_new_data;
        r_hold_valid <= 1'b1;
        r_hold_sof   <= r_sof_pend;
        r_sof_pend   <= 1'b0;
        r_half       <= 1'b0;
      end else begin
        r_byte_hi <= r_data_s;
        r_half    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_byte_cnt    <= '0;
      r_line_cnt    <= '0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_frame_cnt   <= '0;
    end else if (!w_active) begin
      r_byte_cnt <= '0;
      r_line_cnt <= '0;
    end else begin
      if (w_line_end) begin
        r_line_len <= r_byte_cnt;
        r_byte_cnt <= '0;
      end else if (w_cap && !(&r_byte_cnt)) begin
        r_byte_cnt <= r_byte_cnt + CNT_ONE;
      end
      if (w_frame_end) begin
        r_frame_lines <= w_lines_tot;
        r_frame_cnt   <= r_frame_cnt + CNT_ONE;
        r_line_cnt    <= '0;
      end else begin
        r_line_cnt <= w_lines_tot;
      end
    end
  end

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && m_ready;
  assign w_wr_ok = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (w_wr_ok) r_mem[r_wr[AW-1:0]] <= w_push_entry;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr <= r_wr + PTR_ONE;
      if (w_pop)   r_rd <= r_rd + PTR_ONE;
      if (w_push && !w_wr_ok) r_ovf <= 1'b1;
      else if (clr_ovf)       r_ovf <= 1'b0;
    end
  end

  assign m_valid         = !w_empty;
  assign m_data          = w_empty ? '0 : w_head[2*DW-1:0];
  assign m_sof           = !w_empty && w_head[EW-1];
  assign m_eol           = !w_empty && w_head[EW-2];
  assign stu_line_len    = r_line_len;
  assign stu_frame_lines = r_frame_lines;
  assign stu_frame_cnt   = r_frame_cnt;
  assign stu_ovf         = r_ovf;

endmodule

// File: tb/tb_ov_cap.sv
// Bench for ov_cap: table of frame shapes, hand-written corner sequences and random frames,
// all checked against a word-level model of the capture stream.
module tb_ov_cap;
  localparam int DW = 8, VS_FILT = 8, FIFO_DEPTH = 16, CNT_W = 16;

  logic          clk_sys = 1'b0, rst_n = 1'b0;
  logic          ov_vsync = 1'b0, ov_href = 1'b0, ov_pclk = 1'b0;
  logic [DW-1:0] ov_data = '0;
  logic          cfg_en = 1'b0, cfg_vs_pol = 1'b1, cfg_pack = 1'b0, clr_ovf = 1'b0, m_ready = 1'b0;
  logic [2*DW-1:0] m_data;
  logic          m_sof, m_eol, m_valid, stu_ovf;
  logic [CNT_W-1:0] stu_line_len, stu_frame_lines, stu_frame_cnt;

  always #5 clk_sys = ~clk_sys;

  ov_cap #(.DW(DW), .VS_FILT(VS_FILT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ov_vsync(ov_vsync), .ov_href(ov_href), .ov_pclk(ov_pclk),
    .ov_data(ov_data), .cfg_en(cfg_en), .cfg_vs_pol(cfg_vs_pol), .cfg_pack(cfg_pack), .clr_ovf(clr_ovf),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid), .m_ready(m_ready),
    .stu_line_len(stu_line_len), .stu_frame_lines(stu_frame_lines), .stu_frame_cnt(stu_frame_cnt),
    .stu_ovf(stu_ovf)
  );

  typedef struct {
    bit         pack;
    bit         pol;
    int         nlines;
    int         len;
    logic [7:0] base;
    int         exp_len;
    int         exp_lines;
  } vec_t;

  int n_tests = 0, n_fail = 0;
  logic [17:0] got_q[$], exp_q[$];
  logic [7:0]  line_b[$];
  bit rand_ready = 0, ready_fix = 0, sof_pend = 0, prev_stall = 0;
  logic [17:0] prev_w;
  int exp_frames = 0, last_len = 0;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  initial forever begin
    @(posedge clk_sys); #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  always @(negedge clk_sys) begin
    if (rst_n && prev_stall) check("stall_hold", {m_valid, m_sof, m_eol, m_data}, {1'b1, prev_w});
    if (rst_n && m_valid && m_ready) got_q.push_back({m_sof, m_eol, m_data});
    prev_stall = rst_n && m_valid && !m_ready;
    prev_w     = {m_sof, m_eol, m_data};
  end

  function automatic logic vs_lvl(input logic act);
    return cfg_vs_pol ? act : ~act;
  endfunction

  task automatic vs_pulse();
    ov_vsync = vs_lvl(1'b1); wclk(20);
    ov_vsync = vs_lvl(1'b0); wclk(25);
  endtask

  task automatic send_line(input int drop_at);
    ov_href = 1'b1;
    foreach (line_b[i]) begin
      ov_data = line_b[i]; ov_pclk = 1'b0; wclk(4);
      ov_pclk = 1'b1; wclk(4);
      if (i == drop_at) cfg_en = 1'b0;
    end
    ov_pclk = 1'b0; wclk(2);
    ov_href = 1'b0; wclk(10);
  endtask

  task automatic fill_line(input int n, input logic [7:0] start, input bit rnd);
    line_b.delete();
    for (int i = 0; i < n; i++) line_b.push_back(rnd ? 8'($urandom) : start + 8'(i));
  endtask

  // Expected words of one line: bytes taken singly or in pairs, trailing odd byte lost.
  task automatic model_line(input bit pack);
    int nw;
    logic [15:0] d;
    nw = pack ? line_b.size() / 2 : line_b.size();
    for (int k = 0; k < nw; k++) begin
      d = pack ? {line_b[2*k], line_b[2*k+1]} : {8'h00, line_b[k]};
      exp_q.push_back({sof_pend, (k == nw - 1), d});
      sof_pend = 0;
    end
  endtask

  task automatic drain_compare(input string name);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 2000) begin wclk(1); t++; end
    wclk(20);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check({name, "_word"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic start_capture(input bit pol);
    cfg_en = 1'b0; wclk(3);
    cfg_vs_pol = pol;
    ov_vsync = vs_lvl(1'b0); wclk(20);
    cfg_en = 1'b1; wclk(5);
    vs_pulse();
    sof_pend = 1;
  endtask

  task automatic run_frame(input bit pack, input int nlines, input int len, input logic [7:0] base, input bit rnd);
    int n;
    cfg_pack = pack;
    for (int l = 0; l < nlines; l++) begin
      n = rnd ? int'($urandom_range(1, 12)) : len;
      fill_line(n, base + 8'(l * len), rnd);
      model_line(pack);
      send_line(-1);
      last_len = n;
    end
    vs_pulse();
    exp_frames++;
    sof_pend = 1;
  endtask

  task automatic check_status(input string name, input int len, input int lines);
    check({name, "_line_len"}, stu_line_len, len);
    check({name, "_frame_lines"}, stu_frame_lines, lines);
    check({name, "_frame_cnt"}, stu_frame_cnt, exp_frames);
  endtask

  initial begin
    #2ms;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    tbl[0] = '{0, 1, 4, 6, 8'h00, 6, 4};
    tbl[1] = '{1, 1, 3, 8, 8'h40, 8, 3};
    tbl[2] = '{0, 0, 4, 6, 8'h00, 6, 4};
    tbl[3] = '{1, 0, 2, 7, 8'h80, 7, 2};

    wclk(3);
    check("rst_valid", m_valid, 0);
    check("rst_data", {m_sof, m_eol, m_data}, 0);
    check("rst_status", {stu_line_len, stu_frame_lines}, 0);
    check("rst_cnt_ovf", {stu_frame_cnt, stu_ovf}, 0);
    @(posedge clk_sys); #1 rst_n = 1'b1;
    ready_fix = 1;

    for (int i = 0; i < 4; i++) begin
      if (i == 0 || tbl[i].pol != cfg_vs_pol) start_capture(tbl[i].pol);
      run_frame(tbl[i].pack, tbl[i].nlines, tbl[i].len, tbl[i].base, 0);
      drain_compare("table");
      check_status("table", tbl[i].exp_len, tbl[i].exp_lines);
    end
    start_capture(1'b1);

    // Pack mode with an odd trailing byte.
    cfg_pack = 1'b1;
    line_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    send_line(-1);
    vs_pulse(); exp_frames++;
    wclk(20);
    check("pack_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("pack_w0", got_q[0], {1'b1, 1'b0, 16'hA1B2});
      check("pack_w1", got_q[1], {1'b0, 1'b1, 16'hC3D4});
    end
    check_status("pack", 5, 1);
    got_q.delete(); sof_pend = 1;

    // Short vsync glitch inside a frame must not end it.
    cfg_pack = 1'b0;
    fill_line(4, 8'h50, 0); model_line(0); send_line(-1);
    ov_vsync = vs_lvl(1'b1); wclk(3);
    ov_vsync = vs_lvl(1'b0); wclk(20);
    check("glitch_frame_cnt", stu_frame_cnt, exp_frames);
    fill_line(4, 8'h54, 0); model_line(0); send_line(-1);
    vs_pulse(); exp_frames++; sof_pend = 1;
    drain_compare("glitch");
    check_status("glitch", 4, 2);

    // Stalled sink: FIFO keeps the first FIFO_DEPTH words, rest dropped with overflow.
    ready_fix = 0; wclk(3);
    run_frame(0, 4, 10, 8'h20, 0);
    while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
    check("ovf_set", stu_ovf, 1);
    check("ovf_valid", m_valid, 1);
    check("ovf_none_out", got_q.size(), 0);
    @(posedge clk_sys); #1 clr_ovf = 1'b1;
    @(posedge clk_sys); #1 clr_ovf = 1'b0;
    wclk(1);
    check("ovf_clr", stu_ovf, 0);
    ready_fix = 1;
    drain_compare("ovf");
    check_status("ovf", 10, 4);

    // Enable mid-frame: nothing until a full vsync pulse has passed.
    cfg_en = 1'b0; wclk(3);
    vs_pulse();
    fill_line(6, 8'h60, 0); send_line(-1);
    cfg_en = 1'b1;
    fill_line(6, 8'h70, 0); send_line(-1);
    vs_pulse(); sof_pend = 1;
    fill_line(5, 8'h90, 0); model_line(0); send_line(-1);
    vs_pulse(); exp_frames++; sof_pend = 1;
    drain_compare("en_mid");
    check_status("en_mid", 5, 1);

    // Disable mid-line: words already pushed drain, held word lost, no eol.
    fill_line(6, 8'hB0, 0);
    for (int k = 0; k < 3; k++) exp_q.push_back({(k == 0), 1'b0, 8'h00, line_b[k]});
    send_line(3);
    wclk(20);
    drain_compare("en_drop");
    check("en_drop_valid", m_valid, 0);
    check("en_drop_frame_cnt", stu_frame_cnt, exp_frames);
    start_capture(1'b1);

    // Random frames with a random-ready sink.
    rand_ready = 1;
    for (int f = 0; f < 6; f++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 0, 8'h00, 1);
      drain_compare("rand");
      check("rand_line_len", stu_line_len, last_len);
      check("rand_frame_cnt", stu_frame_cnt, exp_frames);
    end
    rand_ready = 0;

    // Reset mid-line with words waiting.
    ready_fix = 0; cfg_pack = 1'b0; wclk(3);
    ov_href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ov_data = 8'hC0 + 8'(i); ov_pclk = 1'b0; wclk(4);
      ov_pclk = 1'b1; wclk(4);
    end
    check("pre_rst_valid", m_valid, 1);
    @(posedge clk_sys); #1 rst_n = 1'b0;
    wclk(3);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", {m_sof, m_eol, m_data}, 0);
    check("mid_rst_status", {stu_line_len, stu_frame_lines}, 0);
    check("mid_rst_cnt_ovf", {stu_frame_cnt, stu_ovf}, 0);
    ov_pclk = 1'b0; ov_href = 1'b0;
    @(posedge clk_sys); #1 rst_n = 1'b1;
    wclk(5);
    check("post_rst_valid", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
